// File: rtl/clock_reset_sequencer.sv
// Clock subsystem power-up/recovery sequencer: pulses PLL reset, waits for stable lock,
// then releases SDRAM, video and audio resets in order. Optional macro: SEQ_SOFT_RESET_EN.
module clock_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 270000,
  parameter int unsigned SDRAM_INIT_CYCLES   = 5400,
  parameter int unsigned DOMAIN_GAP_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_135_lock,
  input  logic       clk_sdram_lock,
  output logic       pll_rst,
  output logic       sdram_rst,
  output logic       video_rst,
  output logic       audio_rst,
  output logic       sys_ready,
  output logic [3:0] retry_count,
  output logic [2:0] seq_state
`ifdef SEQ_SOFT_RESET_EN
  ,
  input  logic       soft_rst_req
`endif
);

  localparam int unsigned MAX_A = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                  PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_B = (SDRAM_INIT_CYCLES > DOMAIN_GAP_CYCLES) ?
                                  SDRAM_INIT_CYCLES : DOMAIN_GAP_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_P = (MAX_C > LOCK_TIMEOUT_CYCLES) ? MAX_C : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_P) + 1;
  localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    StPllReset = 3'd0,
    StWaitLock = 3'd1,
    StRelSdram = 3'd2,
    StRelVideo = 3'd3,
    StRelAudio = 3'd4,
    StRun      = 3'd5
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [TO_W-1:0]    to_q;
  logic [1:0]         lock_meta_q;
  logic [1:0]         lock_sync_q;
  logic               locks_ok;
  logic               soft_req;
  logic               lock_fault;

`ifdef SEQ_SOFT_RESET_EN
  assign soft_req = soft_rst_req;
`else
  assign soft_req = 1'b0;
`endif

  // Two-flop synchronizers for the asynchronous PLL lock inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta_q <= 2'b00;
      lock_sync_q <= 2'b00;
    end else begin
      lock_meta_q <= {clk_135_lock, clk_sdram_lock};
      lock_sync_q <= lock_meta_q;
    end
  end

  assign locks_ok   = &lock_sync_q;
  assign lock_fault = !locks_ok && (state_q inside {StRelSdram, StRelVideo, StRelAudio, StRun});
  assign seq_state  = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StPllReset;
      cnt_q       <= '0;
      to_q        <= '0;
      pll_rst     <= 1'b1;
      sdram_rst   <= 1'b1;
      video_rst   <= 1'b1;
      audio_rst   <= 1'b1;
      sys_ready   <= 1'b0;
      retry_count <= 4'd0;
    end else if (soft_req || lock_fault) begin
      // Restart from PLL reset without counting a retry
      state_q   <= StPllReset;
      cnt_q     <= '0;
      pll_rst   <= 1'b1;
      sdram_rst <= 1'b1;
      video_rst <= 1'b1;
      audio_rst <= 1'b1;
      sys_ready <= 1'b0;
    end else begin
      case (state_q)
        StPllReset: begin
          if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
            state_q <= StWaitLock;
            pll_rst <= 1'b0;
            cnt_q   <= CNT_W'(LOCK_STABLE_CYCLES - 1);
            to_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitLock: begin
          // Stable completion takes priority over a simultaneous timeout
          if (locks_ok && cnt_q == '0) begin
            state_q   <= StRelSdram;
            sdram_rst <= 1'b0;
            cnt_q     <= CNT_W'(SDRAM_INIT_CYCLES - 1);
          end else if (to_q == TO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            state_q <= StPllReset;
            pll_rst <= 1'b1;
            cnt_q   <= '0;
            if (retry_count != 4'hF) retry_count <= retry_count + 4'd1;
          end else begin
            to_q  <= to_q + 1'b1;
            cnt_q <= locks_ok ? cnt_q - 1'b1 : CNT_W'(LOCK_STABLE_CYCLES - 1);
          end
        end
        StRelSdram: begin
          if (cnt_q == '0) begin
            state_q   <= StRelVideo;
            video_rst <= 1'b0;
            cnt_q     <= CNT_W'(DOMAIN_GAP_CYCLES - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StRelVideo: begin
          if (cnt_q == '0) begin
            state_q   <= StRelAudio;
            audio_rst <= 1'b0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StRelAudio: begin
          state_q   <= StRun;
          sys_ready <= 1'b1;
          cnt_q     <= '0;
        end
        StRun: begin
          sys_ready <= 1'b1;
        end
        default: begin
          state_q   <= StPllReset;
          cnt_q     <= '0;
          pll_rst   <= 1'b1;
          sdram_rst <= 1'b1;
          video_rst <= 1'b1;
          audio_rst <= 1'b1;
          sys_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
